// File: rtl/types_pkg.sv
// Shared types for the stream cipher datapath.
// interface_state_t is the interface FSM state seen by the output stage.
package types_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } interface_state_t;

endpackage

// File: rtl/output_queue_ack_edge_sync.sv
// Synchronises an asynchronous user pin and emits a one-cycle pulse on its rising edge.
// All flops reset high so a pin already held high through reset never produces a pulse.
module ack_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pop_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign pop_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/output_queue.sv
// Output stage of the stream cipher: FIFO of ciphertext words popped by rising
// edges of the user acknowledge pin, plus the registered input_acknowledged flag.
module output_queue
   import types_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  interface_state_t               interface_state,
   input  logic                           output_acknowledge,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           output_byte_is_ready,
   output logic                           input_acknowledged,
   output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
   output logic                           overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic                  r_in_ack;

   logic w_pop_pulse;
   logic w_push;
   logic w_pop;
   logic w_not_empty;

   ack_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk       (clk),
      .rst       (rst),
      .async_in  (output_acknowledge),
      .pop_pulse (w_pop_pulse)
   );

   assign w_not_empty = (r_count != '0);
   assign in_ready    = (r_count != CW'(DEPTH));
   assign w_push      = in_valid && in_ready;
   assign w_pop       = w_pop_pulse && w_not_empty;

   // Storage is deliberately not reset; the count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_in_ack   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
         if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
         end
         r_in_ack <= (interface_state != IDLE);
      end
   end

   assign data_out             = w_not_empty ? r_mem[r_rd_ptr] : '0;
   assign output_byte_is_ready = w_not_empty;
   assign fifo_count           = r_count;
   assign overflow             = r_overflow;
   assign input_acknowledged   = r_in_ack;

endmodule

// File: tb/tb_output_queue.sv
// Self-checking bench for output_queue: fixed vector table, directed multi-cycle
// sequences and a randomized run compared against a queue-based reference model.
module tb_output_queue;
   import types_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int S     = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DW-1:0]        in_data;
   logic                 in_valid;
   logic                 in_ready;
   interface_state_t     interface_state;
   logic                 output_acknowledge;
   logic [DW-1:0]        data_out;
   logic                 output_byte_is_ready;
   logic                 input_acknowledged;
   logic [CW-1:0]        fifo_count;
   logic                 overflow;

   always #5 clk = ~clk;

   output_queue #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (S)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_data              (in_data),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .interface_state      (interface_state),
      .output_acknowledge   (output_acknowledge),
      .data_out             (data_out),
      .output_byte_is_ready (output_byte_is_ready),
      .input_acknowledged   (input_acknowledged),
      .fifo_count           (fifo_count),
      .overflow             (overflow)
   );

   int n_vec  = 0;
   int n_fail = 0;
   bit use_model = 1'b0;

   // Reference model: FIFO contents as a queue, pin samples as a history list.
   logic [DW-1:0] m_q[$];
   bit            m_hist[$];
   bit            m_ovf;
   bit            m_ia;

   task automatic model_reset();
      m_q.delete();
      m_hist.delete();
      repeat (S+1) m_hist.push_back(1'b1);
      m_ovf = 1'b0;
      m_ia  = 1'b0;
   endtask

   // A pin rise first sampled at edge k pops at edge k+S.
   task automatic model_edge();
      bit pop;
      int n;
      if (rst) begin
         model_reset();
      end else begin
         pop = m_hist[m_hist.size()-S] && !m_hist[m_hist.size()-S-1];
         n   = m_q.size();
         if (in_valid && n == DEPTH) m_ovf = 1'b1;
         if (pop && n != 0) void'(m_q.pop_front());
         if (in_valid && n < DEPTH) m_q.push_back(in_data);
         m_hist.push_back(output_acknowledge);
         if (m_hist.size() > S+2) void'(m_hist.pop_front());
         m_ia = (interface_state != IDLE);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [DW-1:0] exp_d;
      exp_d = (m_q.size() != 0) ? m_q[0] : '0;
      chk("m_count",   32'(fifo_count),           32'(m_q.size()));
      chk("m_data",    32'(data_out),             32'(exp_d));
      chk("m_obr",     32'(output_byte_is_ready), 32'(m_q.size() != 0));
      chk("m_inready", 32'(in_ready),             32'(m_q.size() != DEPTH));
      chk("m_ovf",     32'(overflow),             32'(m_ovf));
      chk("m_ia",      32'(input_acknowledged),   32'(m_ia));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (use_model) model_check();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic ack_pop();
      output_acknowledge = 1'b1;
      repeat (4) cycle();
      output_acknowledge = 1'b0;
      repeat (4) cycle();
   endtask

   typedef struct {
      logic             rst;
      logic             valid;
      logic [DW-1:0]    data;
      logic             ack;
      interface_state_t st;
      logic [CW-1:0]    e_cnt;
      logic [DW-1:0]    e_data;
      logic             e_obr;
      logic             e_inr;
      logic             e_ovf;
      logic             e_ia;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [DW-1:0] exp_a[3];
      logic [DW-1:0] exp_c[4];
      logic [DW-1:0] prev;
      int hold;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, IDLE,  3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, IDLE,  3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, LOAD,  3'd1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, LOAD,  3'd1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, RUN,   3'd1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, IDLE,  3'd1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 8'h5A, 1'b1, IDLE,  3'd2, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 8'h3C, 1'b0, IDLE,  3'd3, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 8'h77, 1'b0, FLUSH, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, IDLE,  3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      output_acknowledge = 1'b1;
      interface_state = IDLE;
      model_reset();

      // Table: reset with pin high, push without spurious pop, state lag, mid-burst reset.
      use_model = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rst                = tbl[i].rst;
         in_valid           = tbl[i].valid;
         in_data            = tbl[i].data;
         output_acknowledge = tbl[i].ack;
         interface_state    = tbl[i].st;
         cycle();
         chk($sformatf("t%0d_count", i), 32'(fifo_count),           32'(tbl[i].e_cnt));
         chk($sformatf("t%0d_data", i),  32'(data_out),             32'(tbl[i].e_data));
         chk($sformatf("t%0d_obr", i),   32'(output_byte_is_ready), 32'(tbl[i].e_obr));
         chk($sformatf("t%0d_inr", i),   32'(in_ready),             32'(tbl[i].e_inr));
         chk($sformatf("t%0d_ovf", i),   32'(overflow),             32'(tbl[i].e_ovf));
         chk($sformatf("t%0d_ia", i),    32'(input_acknowledged),   32'(tbl[i].e_ia));
      end
      in_valid = 1'b0;
      interface_state = IDLE;
      use_model = 1'b1;

      // Pop timing: head changes exactly at the third edge after the pin rises.
      output_acknowledge = 1'b0;
      do_reset();
      push(8'h11); push(8'h22); push(8'h33);
      exp_a[0] = 8'h22; exp_a[1] = 8'h33; exp_a[2] = 8'h00;
      prev = 8'h11;
      for (int k = 0; k < 3; k++) begin
         output_acknowledge = 1'b1;
         cycle(); chk("seqA_hold1", 32'(data_out), 32'(prev));
         cycle(); chk("seqA_hold2", 32'(data_out), 32'(prev));
         cycle(); chk("seqA_pop",   32'(data_out), 32'(exp_a[k]));
         cycle();
         output_acknowledge = 1'b0;
         repeat (4) cycle();
         prev = exp_a[k];
      end
      chk("seqA_obr_low", 32'(output_byte_is_ready), 32'd0);

      // Overflow: fifth word is dropped and the flag is sticky.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         push(DW'(i));
         if (i == 4) chk("seqB_inready_low", 32'(in_ready), 32'd0);
      end
      chk("seqB_ovf", 32'(overflow), 32'd1);
      chk("seqB_count", 32'(fifo_count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("seqB_head", 32'(data_out), 32'(i));
         ack_pop();
      end
      chk("seqB_empty", 32'(fifo_count), 32'd0);
      chk("seqB_ovf_sticky", 32'(overflow), 32'd1);

      // Pointer wrap-around.
      do_reset();
      push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
      chk("seqC_full", 32'(fifo_count), 32'd4);
      ack_pop(); ack_pop();
      chk("seqC_two", 32'(fifo_count), 32'd2);
      push(8'hC0); push(8'hC1);
      chk("seqC_refull", 32'(fifo_count), 32'd4);
      exp_c[0] = 8'hD2; exp_c[1] = 8'hD3; exp_c[2] = 8'hC0; exp_c[3] = 8'hC1;
      for (int i = 0; i < 4; i++) begin
         chk("seqC_head", 32'(data_out), 32'(exp_c[i]));
         ack_pop();
      end
      chk("seqC_empty", 32'(fifo_count), 32'd0);

      // Push and pop on the same edge at count 2.
      do_reset();
      push(8'hE0); push(8'hE1);
      output_acknowledge = 1'b1;
      cycle(); cycle();
      in_valid = 1'b1;
      in_data  = 8'hE2;
      cycle();
      in_valid = 1'b0;
      chk("seqD_count", 32'(fifo_count), 32'd2);
      chk("seqD_head",  32'(data_out),   32'hE1);
      cycle();
      output_acknowledge = 1'b0;
      repeat (4) cycle();
      ack_pop();
      chk("seqD_tail", 32'(data_out), 32'hE2);
      ack_pop();
      chk("seqD_empty", 32'(fifo_count), 32'd0);

      // Randomized run against the model.
      do_reset();
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 2) == 0);
         in_data  = DW'($urandom);
         interface_state = interface_state_t'($urandom_range(0, 3));
         if (hold == 0) begin
            output_acknowledge = ~output_acknowledge;
            hold = $urandom_range(S+1, S+4);
         end
         hold--;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/output_queue.md
# output_queue

Parametrised output stage for the stream cipher, sitting between the cipher core and the chip output pins. It buffers up to DEPTH ciphertext bytes in a FIFO and presents the oldest byte on `data_out` with `output_byte_is_ready`. It pops a byte on each rising edge of the user's `output_acknowledge` pin, which is synchronised internally. It also produces a registered `input_acknowledged` from the interface FSM state.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each buffered word and of `data_out`
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- SYNC_STAGES, 2, flops in the `output_acknowledge` synchroniser; ≥ 2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_WIDTH  word from cipher core
- in_valid  in  1  push request
- in_ready  out  1  high when FIFO not full
- interface_state  in  interface_state_t  current interface FSM state
- output_acknowledge  in  1  user pin, asynchronous to clk; rising edge = head consumed
- data_out  out  DATA_WIDTH  head entry; all zeros when empty
- output_byte_is_ready  out  1  high while FIFO non-empty
- input_acknowledged  out  1  registered (interface_state != IDLE)
- fifo_count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH
- overflow  out  1  sticky; push attempted while full

## Operation
- Push: `in_valid && in_ready` writes `in_data` at the write pointer; the write pointer increments.
- `in_ready = (fifo_count != DEPTH)`, combinational from registered count.
- Push while full (`in_valid && !in_ready`): word dropped, state unchanged, `overflow` set to 1. `overflow` is cleared only by `rst`.
- Pop: `pop_pulse && fifo_count != 0` increments the read pointer.
  - `pop_pulse` while empty is ignored; count stays 0, no underflow.
- Push and pop in the same cycle (non-empty, non-full): both take effect; count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `fifo_count` is a separate register, +1 on push only, −1 on pop only.
- `data_out = (fifo_count != 0) ? mem[rd_ptr] : '0`, driven from registered state only.
- `output_byte_is_ready = (fifo_count != 0)`.
- Synchroniser: `output_acknowledge` → s[0] → … → s[SYNC_STAGES-1], then one history flop p.
  - `pop_pulse = s[SYNC_STAGES-1] & ~p`.
  - Holding the pin high yields exactly one pop; the pin must fall before the next pop.
- `input_acknowledged` flop: next value is `interface_state != IDLE`.

## Timing
- Reset values:
  - `fifo_count` = 0, pointers = 0
  - `data_out` = 0, `output_byte_is_ready` = 0, `in_ready` = 1
  - `overflow` = 0, `input_acknowledged` = 0
  - all synchroniser flops and p = 1, so a pin held high through reset produces no pop.
  - FIFO memory contents are not reset.
- Push latency: word pushed at edge k appears on `data_out` and raises `output_byte_is_ready` after edge k.
- Pop latency: pin first sampled high at edge k → s[SYNC_STAGES-1] high after edge k+SYNC_STAGES-1 → pop at edge k+SYNC_STAGES. With the default, the pop is at the 2nd edge after first sampling; the next head appears after that edge.
- `input_acknowledged` lags `interface_state` by one cycle.
- Reset mid-operation: all buffered data discarded. Outputs take reset values after the reset edge. An acknowledge edge in flight is lost.
- Minimum acknowledge spacing: pin high ≥ SYNC_STAGES+1 cycles and low ≥ SYNC_STAGES+1 cycles; faster toggling may merge pops.

## Structure
- `types_pkg`: existing `interface_state_t`. No new typedefs; widths are derived from parameters locally.
- Sub-module `ack_edge_sync`: parameter SYNC_STAGES; input async pin; output single-cycle `pop_pulse`; resets to all ones. Reusable for other user pins.
- Top `output_queue`: FIFO memory, pointers, count, overflow flag, `input_acknowledged` flop.

## Test plan
- Reset with `output_acknowledge` = 1 held; release reset and push 0xA5 → `data_out` = 0xA5 stays, count = 1, no spurious pop.
- Push 0x11, 0x22, 0x33; toggle ack three times, each high/low 4 cycles → `data_out` sequence 0x11, 0x22, 0x33, then 0x00. Each change occurs exactly SYNC_STAGES+1 edges after the pin rise. `output_byte_is_ready` falls after the third pop.
- DEPTH=4: push 5 words 0x01..0x05 back-to-back → `in_ready` low after the 4th push, 0x05 dropped, `overflow` = 1 and stays 1. Later pops return 0x01..0x04.
- Wrap-around: fill 4 words, pop 2, push 0xC0, 0xC1 → pops return the remaining 2 words, then 0xC0, 0xC1. `fifo_count` goes 4,2,4,…,0.
- Simultaneous push and pop at count = 2 → count stays 2, the head advances, and the new word lands at the tail.
- `interface_state` IDLE→non-IDLE→IDLE for 3 cycles → `input_acknowledged` high for exactly those 3 cycles, delayed by 1. Asserting `rst` mid-burst with count = 3 → count 0, `data_out` 0, `overflow` 0 next cycle.
